// File: rtl/fetch_stage_pkg.sv
// Shared RV32I pipeline types used by the fetch stage: FSM state encoding,
// the NOP encoding and a PC alignment helper.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction addresses are word aligned; low bits of a target are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// One-entry instruction/PC holding register with a valid bit, used to keep a
// cache response alive while the pipeline is stalled.
module fetch_skid_buf
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one cache read in flight
// and squashes it on EX redirects. Optional skid buffer: FETCH_SKID_BUF_EN.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] i_mem_addr,
  output logic        i_mem_read,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        i_resp,
  output logic [1:0]  o_dbg_state
);

  // Handshake: an instruction transfers on i_resp && !stall_id. i_resp never
  // looks at stall_id; the cache request (i_mem_read/i_mem_addr) stays fixed
  // until i_mem_resp.
  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, w_next_pc;
  logic [31:0]  r_tgt, w_next_tgt;
  logic [31:0]  w_redirect_tgt;
  logic         w_accept;

`ifdef FETCH_SKID_BUF_EN
  logic        w_buf_load;
  logic        w_buf_clear;
  logic        w_buf_valid;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;

  fetch_skid_buf u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (i_mem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );
`endif

  assign w_redirect_tgt = align_pc(redirect_pc);
  assign w_accept       = i_resp && !stall_id;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= PC_RESET;
      r_tgt   <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_tgt   <= w_next_tgt;
    end
  end

  always_comb begin
    i_mem_addr  = r_pc;
    i_mem_read  = (r_state == FETCH) || (r_state == SQUASH);
    i_resp      = 1'b0;
    instruction = NOP_INSTR;
    inst_pc     = r_pc;
    if (r_state == FETCH && i_mem_resp) begin
      i_resp      = 1'b1;
      instruction = i_mem_rdata;
    end
`ifdef FETCH_SKID_BUF_EN
    if (r_state == HOLD && w_buf_valid) begin
      i_resp      = 1'b1;
      instruction = w_buf_instr;
      inst_pc     = w_buf_pc;
    end
`endif
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_tgt   = r_tgt;
`ifdef FETCH_SKID_BUF_EN
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        // Redirect wins over accept; a same-cycle response is still shown.
        if (redirect) begin
          if (i_mem_resp) begin
            w_next_pc = w_redirect_tgt;
          end else begin
            w_next_state = SQUASH;
            w_next_tgt   = w_redirect_tgt;
          end
        end else if (w_accept) begin
          w_next_pc = r_pc + 32'd4;
`ifdef FETCH_SKID_BUF_EN
        end else if (i_mem_resp) begin
          w_next_state = HOLD;
          w_buf_load   = 1'b1;
`endif
        end
      end
      HOLD: begin
`ifdef FETCH_SKID_BUF_EN
        if (redirect) begin
          w_next_state = FETCH;
          w_next_pc    = w_redirect_tgt;
          w_buf_clear  = 1'b1;
        end else if (w_accept) begin
          w_next_state = FETCH;
          w_next_pc    = r_pc + 32'd4;
          w_buf_clear  = 1'b1;
        end
`else
        w_next_state = FETCH;
`endif
      end
      SQUASH: begin
        if (redirect) begin
          w_next_tgt = w_redirect_tgt;
        end
        if (i_mem_resp) begin
          w_next_state = FETCH;
          w_next_pc    = redirect ? w_redirect_tgt : r_tgt;
        end
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/latency traffic against a flag-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] PC_RST = 32'h0000_0060;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] i_mem_addr;
  logic        i_mem_read;
  logic [31:0] i_mem_rdata;
  logic        i_mem_resp;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        i_resp;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(PC_RST)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .i_mem_addr  (i_mem_addr),
    .i_mem_read  (i_mem_read),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_resp  (i_mem_resp),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .i_resp      (i_resp),
    .o_dbg_state (o_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: address that should be fetched, whether the in-flight
  // response must be thrown away, and whether an instruction is being held.
  logic [31:0] m_pc, m_tgt, m_instr;
  bit          m_discard, m_held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = PC_RST;
    m_tgt     = 32'h0;
    m_instr   = NOP;
    m_discard = 1'b0;
    m_held    = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs 1ns
  // later, then advance the model to what the next rising edge should do.
  task automatic drive_cycle(input logic r, input logic st, input logic rd,
                             input logic [31:0] rpc, input logic want_resp,
                             input logic [31:0] data_in, input bit auto_data);
    logic        resp;
    logic        exp_resp;
    logic [31:0] data;
    logic [31:0] t;
    logic [31:0] shown;
    @(negedge clk);
    rst         = r;
    stall_id    = st;
    redirect    = rd;
    redirect_pc = rpc;
    data        = auto_data ? mem_word(i_mem_addr) : data_in;
    resp        = want_resp && i_mem_read;
    i_mem_resp  = resp;
    i_mem_rdata = resp ? data : 32'hDEAD_BEEF;
    #1;
    if (r) begin
      model_reset();
    end else begin
      exp_resp = m_held || (resp && !m_discard);
      shown    = m_held ? m_instr : data;
      check("i_mem_read", {31'b0, i_mem_read}, {31'b0, !m_held});
      if (!m_held) check("i_mem_addr", i_mem_addr, m_pc);
      check("i_resp", {31'b0, i_resp}, {31'b0, exp_resp});
      if (exp_resp) begin
        check("inst_pc", inst_pc, m_pc);
        check("instruction", instruction, shown);
      end
      if (exp_resp && !st) exp_q.push_back(shown);
      if (i_resp && !st) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_accepted", instruction, exp_q.pop_front());
      end
      t = {rpc[31:2], 2'b00};
      if (rd) begin
        if (m_discard) begin
          if (resp) begin
            m_pc      = t;
            m_discard = 1'b0;
          end else begin
            m_tgt = t;
          end
        end else if (m_held || resp) begin
          m_pc   = t;
          m_held = 1'b0;
        end else begin
          m_discard = 1'b1;
          m_tgt     = t;
        end
      end else if (m_discard) begin
        if (resp) begin
          m_pc      = m_tgt;
          m_discard = 1'b0;
        end
      end else if (exp_resp && !st) begin
        m_pc   = m_pc + 32'd4;
        m_held = 1'b0;
      end else if (resp) begin
`ifdef FETCH_SKID_BUF_EN
        m_held  = 1'b1;
        m_instr = data;
`endif
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    i_mem_resp = 1'b0; i_mem_rdata = 32'h0;
    model_reset();
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0);

    // Reset values
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    check("rst_read", {31'b0, i_mem_read}, 32'd1);
    check("rst_addr", i_mem_addr, 32'h60);
    check("rst_resp", {31'b0, i_resp}, 32'd0);
    check("rst_instr", instruction, 32'h13);
    check("rst_inst_pc", inst_pc, 32'h60);

    // First hit and back-to-back hits
    drive_cycle(0, 0, 0, 0, 1, 32'h0000_0093, 0);
    check("first_resp", {31'b0, i_resp}, 32'd1);
    check("first_instr", instruction, 32'h93);
    check("first_pc", inst_pc, 32'h60);
    for (int i = 1; i < 4; i++) begin
      drive_cycle(0, 0, 0, 0, 1, mem_word(32'h60 + 32'(4 * i)), 0);
      if (i == 1) check("next_addr", i_mem_addr, 32'h64);
      check("b2b_pc", inst_pc, 32'h60 + 32'(4 * i));
      check("b2b_read", {31'b0, i_mem_read}, 32'd1);
    end

    // Redirect to 0x200 while the 0x70 request waits
    drive_cycle(0, 0, 1, 32'h200, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1, mem_word(32'h70), 0);
    check("squash_addr", i_mem_addr, 32'h70);
    check("squash_resp", {31'b0, i_resp}, 32'd0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    check("redir_addr", i_mem_addr, 32'h200);

    // Response while stalled for 3 cycles
    drive_cycle(0, 1, 0, 0, 1, mem_word(32'h200), 0);
    check("stall_resp0", {31'b0, i_resp}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 1, 0, 0, 1, mem_word(32'h200), 0);
`ifdef FETCH_SKID_BUF_EN
      check("hold_resp", {31'b0, i_resp}, 32'd1);
      check("hold_read", {31'b0, i_mem_read}, 32'd0);
`else
      check("refetch_read", {31'b0, i_mem_read}, 32'd1);
      check("refetch_addr", i_mem_addr, 32'h200);
`endif
    end
    drive_cycle(0, 0, 0, 0, 1, mem_word(32'h200), 0);
    check("stall_accept_pc", inst_pc, 32'h200);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    check("after_stall_addr", i_mem_addr, 32'h204);

    // Redirect to an unaligned target in the same cycle as a response
    drive_cycle(0, 0, 1, 32'h103, 1, mem_word(32'h204), 0);
    check("redir_same_resp", {31'b0, i_resp}, 32'd1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    check("redir_aligned_addr", i_mem_addr, 32'h100);

    // Reset during an outstanding miss
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    check("midrst_addr", i_mem_addr, 32'h60);
    check("midrst_resp", {31'b0, i_resp}, 32'd0);

    // Random traffic
    lat = $urandom_range(0, 3);
    repeat (1500) begin
      drive_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), $urandom, (lat == 0), 32'h0, 1);
      if (i_mem_resp || rst) lat = $urandom_range(0, 3);
      else if (lat > 0) lat--;
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
